// File: rtl/regfile_write_scheduler.sv
// Purpose: round-robin arbiter (ALU vs load writeback) for the single register-file write port, plus a pending-write scoreboard for issue hazards.
// Latency: a writeback granted at edge N drives the write port during cycle N+1; its pending bit reads clear from cycle N+2.
// Backpressure: the requester that is not granted sees ready low and holds valid/rd/data; issue_stall holds the decoded instruction.
//
// Ports:
//   clk, reset (async, active-low)
//   alu_wb_valid/rd/data -> alu_wb_ready      ALU writeback requester
//   mem_wb_valid/rd/data -> mem_wb_ready      load writeback requester
//   issue_valid, issue_writes_rd, issue_rs1/rs2/rd -> issue_stall   decode hazard check
//   register_write_valid, write_reg, reg_write_data                 register file write port
//   pending                                                         scoreboard, bit i = write to xi outstanding
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]        alu_wb_data,
  output logic                         alu_wb_ready,
  input  logic                         mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_wb_rd,
  input  logic [DATA_WIDTH-1:0]        mem_wb_data,
  output logic                         mem_wb_ready,
  input  logic                         issue_valid,
  input  logic                         issue_writes_rd,
  input  logic [ADDR_WIDTH-1:0]        issue_rs1,
  input  logic [ADDR_WIDTH-1:0]        issue_rs2,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic                         issue_stall,
  output logic                         register_write_valid,
  output logic [ADDR_WIDTH-1:0]        write_reg,
  output logic [DATA_WIDTH-1:0]        reg_write_data,
  output logic [(2**ADDR_WIDTH)-1:0]   pending
);

  localparam int NREG = 2**ADDR_WIDTH;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e                  last_grant;
  logic                  grant_alu;
  logic                  grant_mem;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xfer_rd;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  xfer_writes;
  logic [NREG-1:0]       pending_set;
  logic [NREG-1:0]       pending_clr;
  logic [NREG-1:0]       pending_nxt;
  logic                  hit_rs1;
  logic                  hit_rs2;
  logic                  hit_rd;

  // Arbitration: a lone requester always wins; on a tie the source that
  // did not win last time is granted. Depends only on inputs and
  // last_grant, never on the write stage.
  always_comb begin
    grant_alu = alu_wb_valid && (!mem_wb_valid || (last_grant == SRC_MEM));
    grant_mem = mem_wb_valid && (!alu_wb_valid || (last_grant == SRC_ALU));
  end

  assign alu_wb_ready = grant_alu;
  assign mem_wb_ready = grant_mem;
  assign xfer         = grant_alu || grant_mem;
  assign xfer_rd      = grant_mem ? mem_wb_rd   : alu_wb_rd;
  assign xfer_data    = grant_mem ? mem_wb_data : alu_wb_data;
  // x0 writebacks are consumed but never reach the register file.
  assign xfer_writes  = xfer && (xfer_rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= SRC_MEM;
    end else if (grant_alu) begin
      last_grant <= SRC_ALU;
    end else if (grant_mem) begin
      last_grant <= SRC_MEM;
    end
  end

  // Write stage: index/data hold their last value while not valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      register_write_valid <= 1'b0;
      write_reg            <= '0;
      reg_write_data       <= '0;
    end else begin
      register_write_valid <= xfer_writes;
      if (xfer_writes) begin
        write_reg      <= xfer_rd;
        reg_write_data <= xfer_data;
      end
    end
  end

  // Hazard check; x0 is never treated as pending.
  always_comb begin
    hit_rs1     = (issue_rs1 != '0) && pending[issue_rs1];
    hit_rs2     = (issue_rs2 != '0) && pending[issue_rs2];
    hit_rd      = issue_writes_rd && (issue_rd != '0) && pending[issue_rd];
    issue_stall = issue_valid && (hit_rs1 || hit_rs2 || hit_rd);
  end

  // Scoreboard update. The set term is applied after the clear term so a
  // new writer issuing on the same edge its older write retires keeps
  // the bit outstanding.
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (issue_valid && !issue_stall && issue_writes_rd) begin
      pending_set[issue_rd] = 1'b1;
    end
    if (register_write_valid) begin
      pending_clr[write_reg] = 1'b1;
    end
    pending_nxt    = (pending & ~pending_clr) | pending_set;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Controller in front of the single-write-port register file of the pipelined RISC-V core. It arbitrates round-robin between the ALU writeback and the load (memory) writeback for the one write port, and drives that port from a registered stage. It also keeps a 32-entry pending-write scoreboard that stalls issue on RAW/WAW hazards, and suppresses writes to x0.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserting low clears all state immediately)
- alu_wb_valid  input  1  ALU writeback request
- alu_wb_rd  input  ADDR_WIDTH  ALU destination register
- alu_wb_data  input  DATA_WIDTH  ALU result
- alu_wb_ready  output  1  ALU request granted this cycle
- mem_wb_valid  input  1  load writeback request
- mem_wb_rd  input  ADDR_WIDTH  load destination register
- mem_wb_data  input  DATA_WIDTH  load data
- mem_wb_ready  output  1  load request granted this cycle
- issue_valid  input  1  decode stage presents an instruction
- issue_writes_rd  input  1  presented instruction writes rd
- issue_rs1, issue_rs2, issue_rd  input  ADDR_WIDTH  source/destination indices
- issue_stall  output  1  hold the presented instruction
- register_write_valid  output  1  to register file write enable
- write_reg  output  ADDR_WIDTH  to register file write index
- reg_write_data  output  DATA_WIDTH  to register file write data
- pending  output  2**ADDR_WIDTH  scoreboard bits (bit i = write to xi outstanding)

## Operation
- Handshake: requester holds valid, rd, data stable until its ready is high. Transfer occurs on a clock edge where valid && ready.
- Grant (combinational): only one requester valid → grant it. Both valid → grant the one not granted last. Neither → no grant. ready = grant; never both high.
- last_grant register: updated to the granted source on every transfer. Reset value = MEM, so the ALU wins the first tie.
- Write stage (registered): on a transfer with rd != 0, next cycle register_write_valid=1 with write_reg/reg_write_data = granted rd/data. Otherwise register_write_valid=0. write_reg/reg_write_data hold their last values when invalid.
- x0: writebacks to rd=0 are accepted (ready high) but never produce register_write_valid. The register file does not protect x0.
- Scoreboard set: on the edge where issue_valid && !issue_stall && issue_writes_rd && issue_rd != 0, pending[issue_rd] ← 1.
- Scoreboard clear: on the edge where register_write_valid=1, pending[write_reg] ← 0.
- Same-edge set and clear of one index: set wins.
- Writeback to a non-pending register: written normally; the scoreboard is unchanged.
- issue_stall = issue_valid && (pending[issue_rs1] || pending[issue_rs2] || (issue_writes_rd && pending[issue_rd])), with index 0 never counted as pending. issue_stall=0 when issue_valid=0.
- pending[0] is always 0.

## Timing
- Reset (async, low): register_write_valid=0, write_reg=0, reg_write_data=0, pending=0, last_grant=MEM. ready and issue_stall follow combinationally from inputs and cleared state.
- A reset asserted mid-operation drops the in-flight write-stage entry and clears all pending bits. Requesters must re-present after release.
- Latency: grant at edge N → register_write_valid high during cycle N+1 → register file written at edge N+1 → pending bit clear from cycle N+2. A dependent instruction stalled in N+1 issues in N+2.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate.
- No combinational path from register_write_valid back to ready.

## Test plan
- Reset then idle: all outputs 0, pending=0. reset pulsed low mid-write → register_write_valid drops to 0 asynchronously.
- ALU only: alu_wb_valid=1, rd=10, data=0x20 → alu_wb_ready=1 same cycle; next cycle register_write_valid=1, write_reg=10, reg_write_data=0x20.
- Both valid from reset, ALU rd=11/0x21 and MEM rd=12/0x15, held for 4 cycles → grants ALU, MEM, ALU, MEM; writes appear one cycle after each grant.
- x0 suppression: mem_wb rd=0, data=0x10 → mem_wb_ready=1, register_write_valid stays 0 next cycle.
- RAW stall: issue rd=5 (writes_rd=1) accepted, then issue rs1=5 → issue_stall=1. ALU writeback rd=5 granted at edge N → stall high through N+1, low in N+2.
- Same-edge set/clear: pending[7]=1 with its writeback completing on the edge where a new writer of x7 issues → pending[7] remains 1 afterward.
